// File: rtl/sync_fifo_ctrl_if.sv
// rtl/sync_fifo_ctrl_if.sv - write/read/status bundle between a FIFO user and sync_fifo_ctrl
interface sync_fifo_ctrl_if #(
  parameter int DEPTH   = 16,
  parameter int D_WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [D_WIDTH-1:0] wr_data;
  logic               w_en;
  logic               r_en;
  logic               err_clr;
  logic [D_WIDTH-1:0] rd_data;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [AW:0]        fill_count;
  logic [AW:0]        bin_w_ptr;
  logic [AW:0]        bin_r_ptr;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_data, w_en, r_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, fill_count,
           bin_w_ptr, bin_r_ptr, overflow, underflow
  );

  modport slave (
    input  wr_data, w_en, r_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, fill_count,
           bin_w_ptr, bin_r_ptr, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - parametrised single-clock FIFO with fill status, sticky errors and debug pointers
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port instead of the registered one.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int D_WIDTH  = 8,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_ctrl_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0] CNT_AF   = AF_LEVEL[AW:0];
  localparam logic [AW:0] CNT_AE   = AE_LEVEL[AW:0];
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]        w_ptr;
  logic [AW:0]        r_ptr;
  logic [AW:0]        count;
  logic               wa;
  logic               ra;
  logic               ovf_q;
  logic               udf_q;

  // Status is decoded from registered state only, so a refused write stays
  // refused even when a read frees a slot in the same cycle.
  assign bus.full         = (count == CNT_FULL);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= CNT_AF);
  assign bus.almost_empty = (count <= CNT_AE);
  assign bus.fill_count   = count;
  assign bus.bin_w_ptr    = w_ptr;
  assign bus.bin_r_ptr    = r_ptr;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  assign wa = bus.w_en & ~bus.full;
  assign ra = bus.r_en & ~bus.empty;

  always_ff @(posedge clk) begin
    if (wa) mem[w_ptr[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wa) w_ptr <= w_ptr + ONE;
      if (ra) r_ptr <= r_ptr + ONE;
      if (wa && !ra)      count <= count + ONE;
      else if (ra && !wa) count <= count - ONE;
    end
  end

  // A fresh error in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.w_en && bus.full) ovf_q <= 1'b1;
      else if (bus.err_clr)     ovf_q <= 1'b0;
      if (bus.r_en && bus.empty) udf_q <= 1'b1;
      else if (bus.err_clr)      udf_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data = mem[r_ptr[AW-1:0]];
`else
  logic [D_WIDTH-1:0] rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rd_q <= '0;
    else if (ra) rd_q <= mem[r_ptr[AW-1:0]];
  end

  assign bus.rd_data = rd_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl against a queue-based model
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sync_fifo_ctrl_if #(.DEPTH(DEPTH), .D_WIDTH(DW)) bus ();

  sync_fifo_ctrl #(.DEPTH(DEPTH), .D_WIDTH(DW), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq[$];
  int         m_wp;
  int         m_rp;
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] m_rd;

  task automatic model_reset();
    mq.delete();
    m_wp  = 0;
    m_rp  = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = 8'h00;
  endtask

  function automatic bit rd_checkable();
`ifdef SYNC_FIFO_FWFT_EN
    return mq.size() > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_rd();
`ifdef SYNC_FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : 8'h00;
`else
    return m_rd;
`endif
  endfunction

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit clr);
    bit wa;
    bit ra;
    wa = w && (mq.size() < DEPTH);
    ra = r && (mq.size() > 0);
    if (w && mq.size() == DEPTH) m_ovf = 1'b1;
    else if (clr)                m_ovf = 1'b0;
    if (r && mq.size() == 0)     m_udf = 1'b1;
    else if (clr)                m_udf = 1'b0;
    if (ra) begin
      m_rd = mq.pop_front();
      m_rp = (m_rp + 1) % 32;
    end
    if (wa) begin
      mq.push_back(d);
      m_wp = (m_wp + 1) % 32;
    end
    bus.w_en    = w;
    bus.r_en    = r;
    bus.wr_data = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", bus.full); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL rst_ae got %b want 1", bus.almost_empty); end
    n_cmp++; if (bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_af got %b want 0", bus.almost_full); end
    n_cmp++; if (bus.fill_count !== 5'd0) begin n_bad++; $display("FAIL rst_fill got %0d want 0", bus.fill_count); end
    n_cmp++; if (bus.bin_w_ptr !== 5'd0 || bus.bin_r_ptr !== 5'd0) begin n_bad++; $display("FAIL rst_ptr got %0h/%0h want 0/0", bus.bin_w_ptr, bus.bin_r_ptr); end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b%b want 00", bus.overflow, bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd got %0h want 0", bus.rd_data); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      n_cmp++; if (bus.fill_count !== 5'(i)) begin n_bad++; $display("FAIL fill_count got %0d want %0d", bus.fill_count, i); end
      n_cmp++; if (bus.almost_full !== (i >= 12)) begin n_bad++; $display("FAIL fill_af at %0d got %b want %b", i, bus.almost_full, (i >= 12)); end
      n_cmp++; if (bus.full !== (i == DEPTH)) begin n_bad++; $display("FAIL fill_full at %0d got %b want %b", i, bus.full, (i == DEPTH)); end
    end
    n_cmp++; if (bus.bin_w_ptr !== 5'h10) begin n_bad++; $display("FAIL fill_wptr got %0h want 10", bus.bin_w_ptr); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    n_cmp++; if (bus.fill_count !== 5'd16 || bus.bin_w_ptr !== 5'h10) begin n_bad++; $display("FAIL ovf_state got %0d/%0h want 16/10", bus.fill_count, bus.bin_w_ptr); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", bus.overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.rd_data !== 8'(i)) begin n_bad++; $display("FAIL drain_head got %0h want %0h", bus.rd_data, i); end
`endif
      step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.rd_data !== 8'(i)) begin n_bad++; $display("FAIL drain_rd got %0h want %0h", bus.rd_data, i); end
`endif
      n_cmp++; if (bus.almost_empty !== ((DEPTH - i) <= 4)) begin n_bad++; $display("FAIL drain_ae at %0d got %b", i, bus.almost_empty); end
      n_cmp++; if (bus.empty !== (i == DEPTH)) begin n_bad++; $display("FAIL drain_empty at %0d got %b", i, bus.empty); end
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set got %b want 1", bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rd_data !== 8'h10) begin n_bad++; $display("FAIL udf_hold got %0h want 10", bus.rd_data); end
`endif
  endtask

  task automatic test_interleave();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      n_cmp++; if (bus.fill_count !== 5'd5) begin n_bad++; $display("FAIL ilv_fill got %0d want 5", bus.fill_count); end
      n_cmp++; if (bus.rd_data !== exp_rd()) begin n_bad++; $display("FAIL ilv_rd got %0h want %0h", bus.rd_data, exp_rd()); end
      n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_bad++; $display("FAIL ilv_err got %b%b want 00", bus.overflow, bus.underflow); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (rd_checkable()) begin
        n_cmp++; if (bus.rd_data !== exp_rd()) begin n_bad++; $display("FAIL ilv_drain got %0h want %0h", bus.rd_data, exp_rd()); end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus.fill_count !== 5'd0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL arst_fill got %0d/%b want 0/1", bus.fill_count, bus.empty); end
    n_cmp++; if (bus.bin_w_ptr !== 5'd0 || bus.bin_r_ptr !== 5'd0) begin n_bad++; $display("FAIL arst_ptr got %0h/%0h want 0/0", bus.bin_w_ptr, bus.bin_r_ptr); end
    n_cmp++; if (bus.underflow !== 1'b0 || bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL arst_flags got udf=%b ae=%b want 0/1", bus.underflow, bus.almost_empty); end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("FAIL arst_rd got %0h want 0", bus.rd_data); end
`endif
    #2 reset = 1'b1;
    step(1'b1, 1'b0, 8'h55, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rd_data !== 8'h55) begin n_bad++; $display("FAIL arst_55 got %0h want 55", bus.rd_data); end
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rd_data !== 8'h55) begin n_bad++; $display("FAIL arst_55 got %0h want 55", bus.rd_data); end
`endif
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5), 8'($urandom), ($urandom_range(0, 19) == 0));
      n_cmp++; if (bus.fill_count !== 5'(mq.size())) begin n_bad++; $display("FAIL rnd_fill got %0d want %0d", bus.fill_count, mq.size()); end
      n_cmp++; if (bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin n_bad++; $display("FAIL rnd_fe got %b%b size %0d", bus.full, bus.empty, mq.size()); end
      n_cmp++; if (bus.almost_full !== (mq.size() >= 12) || bus.almost_empty !== (mq.size() <= 4)) begin n_bad++; $display("FAIL rnd_almost got %b%b size %0d", bus.almost_full, bus.almost_empty, mq.size()); end
      n_cmp++; if (bus.overflow !== m_ovf || bus.underflow !== m_udf) begin n_bad++; $display("FAIL rnd_err got %b%b want %b%b", bus.overflow, bus.underflow, m_ovf, m_udf); end
      n_cmp++; if (bus.bin_w_ptr !== 5'(m_wp) || bus.bin_r_ptr !== 5'(m_rp)) begin n_bad++; $display("FAIL rnd_ptr got %0h/%0h want %0h/%0h", bus.bin_w_ptr, bus.bin_r_ptr, m_wp, m_rp); end
      if (rd_checkable()) begin
        n_cmp++; if (bus.rd_data !== exp_rd()) begin n_bad++; $display("FAIL rnd_rd got %0h want %0h", bus.rd_data, exp_rd()); end
      end
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    n_cmp++; if (bus.rd_data !== 8'h3C || bus.empty !== 1'b0) begin n_bad++; $display("FAIL fwft_head got %0h/%b want 3c/0", bus.rd_data, bus.empty); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL fwft_pop got %b want 1", bus.empty); end
  endtask
`endif

  initial begin
    bus.wr_data = 8'h00;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_interleave();
    test_async_reset();
    test_random();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, the next generation of the team's FIFO family. Generalised depth and width, with a live fill count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It also exports binary pointers for debug, consistent with the existing FIFO family. Used inside single-clock-domain datapaths where the clock-crossing FIFO is unnecessary.

Parameters:
- DEPTH, 16: number of entries; power of two, minimum 4.
- D_WIDTH, 8: data width in bits.
- AF_LEVEL, 12: almost_full asserts when fill_count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when fill_count <= AE_LEVEL; legal range 0..DEPTH-1.
- AW (localparam) = clog2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_data  input  D_WIDTH  write data.
- w_en  input  1  write request.
- r_en  input  1  read request.
- err_clr  input  1  clears the sticky overflow and underflow flags.
- rd_data  output  D_WIDTH  read data.
- full  output  1  fill_count == DEPTH.
- empty  output  1  fill_count == 0.
- almost_full  output  1  fill_count >= AF_LEVEL.
- almost_empty  output  1  fill_count <= AE_LEVEL.
- fill_count  output  AW+1  number of stored entries, 0..DEPTH.
- bin_w_ptr  output  AW+1  binary write pointer; MSB is the wrap bit.
- bin_r_ptr  output  AW+1  binary read pointer; MSB is the wrap bit.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, fill_count=0, rd_data=0, overflow=0, underflow=0, so empty=1, almost_empty=1, full=0, almost_full=0 (given AF_LEVEL >= 1). Memory contents are not reset. Reset asserted mid-operation discards all stored data immediately.
- Write accept: wa = w_en & ~full. On accept, mem[bin_w_ptr[AW-1:0]] <= wr_data and bin_w_ptr increments.
- Read accept: ra = r_en & ~empty. On accept, bin_r_ptr increments.
- full/empty are evaluated on current registered state only. A write while full is refused even if r_en is high in the same cycle; in that case only the read is accepted.
- fill_count: +1 on wa&~ra, -1 on ra&~wa, unchanged otherwise. Must always equal bin_w_ptr - bin_r_ptr modulo 2^(AW+1).
- Pointer wrap: pointers roll over naturally at 2^(AW+1). full when the low AW bits are equal and the MSBs differ; empty when the pointers are equal.
- Status flags: full, empty, almost_* are combinational decodes of registered fill_count. They reflect an accepted operation in the cycle after its edge.
- Standard mode: on ra, rd_data <= mem[bin_r_ptr[AW-1:0]], valid the cycle after the read edge. Otherwise rd_data holds its value.
- Simultaneous read and write in the same cycle, FIFO neither full nor empty: both accepted, count unchanged.
- Simultaneous read and write on an empty FIFO: the write is accepted and the read is refused (underflow sets).
- Error flags: overflow <= 1 on w_en&full; underflow <= 1 on r_en&empty. err_clr=1 clears both on the next edge. If a set condition and err_clr occur in the same cycle, the set wins.
- Refused operations never change pointers, memory or rd_data.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): rd_data = mem[bin_r_ptr[AW-1:0]] combinationally. The head word is visible whenever empty=0, i.e. the cycle after the write edge into an empty FIFO. ra pops the head, and the next word appears in the cycle after the edge. rd_data is don't-care while empty. The rd_data register is removed.
- Undefined: standard registered-read behaviour as described above.

Test Plan:
- After reset, write 0x01..0x10 (16 writes, DEPTH=16) → full=1 after the 16th edge, almost_full first seen after the 12th, fill_count=16, bin_w_ptr=0x10.
- With FIFO full, write 0xAA → refused, overflow=1, contents unchanged. Then pulse err_clr → overflow=0.
- Drain all 16 entries → rd_data sequence 0x01..0x10 (standard mode: each one cycle after its read edge), empty=1, almost_empty from count 4. A further read sets underflow=1 and rd_data holds 0x10.
- Run 40 writes and 40 reads interleaved at a constant depth of 5 → data order preserved across pointer wrap, fill_count constant at 5, no error flags.
- Fill with 7 entries, then assert reset low for a partial cycle → all outputs return to reset values asynchronously. The next write of 0x55 followed by a read returns 0x55.
- With SYNC_FIFO_FWFT_EN defined, write 0x3C into an empty FIFO → rd_data=0x3C and empty=0 in the cycle after the write edge, with no r_en. A read then pops it and empty=1.
